// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter (8N1) with a one-byte holding register and a 5x-baud tick divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module uart_tx #(
    parameter int OSCRATE  = 12_000_000,
    parameter int BAUDRATE = 9600
) (
    input  logic       osc,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);
    localparam int BAUD_DIVISOR = OSCRATE / BAUDRATE / 5;
    localparam int CNT_W        = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
    localparam logic [CNT_W-1:0] TICK_RELOAD = CNT_W'(BAUD_DIVISOR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       shifter_q, shifter_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]       sub_q, sub_d;
    logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic tick, bit_end, accept, load;

    // A bit period ends on the fifth divider tick; load restarts the bit clock so the start bit is full length.
    assign tick    = (tick_cnt_q == '0);
    assign bit_end = tick && (sub_q == 3'd4);
    assign accept  = tx_valid && !hold_full_q;
    assign load    = hold_full_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge osc) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shifter_q   <= '0;
            bit_idx_q   <= '0;
            tick_cnt_q  <= '0;
            sub_q       <= '0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shifter_q   <= shifter_d;
            bit_idx_q   <= bit_idx_d;
            tick_cnt_q  <= tick_cnt_d;
            sub_q       <= sub_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP:  if (bit_end) state_d = load ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shifter_d   = shifter_q;
        bit_idx_d   = bit_idx_q;
        tick_cnt_d  = tick ? TICK_RELOAD : tick_cnt_q - CNT_W'(1);
        sub_d       = tick ? ((sub_q == 3'd4) ? 3'd0 : sub_q + 3'd1) : sub_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (load) begin
            shifter_d   = hold_q;
            hold_full_d = 1'b0;
            bit_idx_d   = 3'd0;
            tick_cnt_d  = TICK_RELOAD;
            sub_d       = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end else if ((state_q == S_DATA) && bit_end) begin
            shifter_d = shifter_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
        end
    end

    // The line level is decoded from next state so tx is a clean flop output aligned with the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shifter_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = !hold_full_q;
    assign busy     = (state_q != S_IDLE);

endmodule
